// File: rtl/decode_stage_buffered_pkg.sv
// Shared definitions for the buffered RV32I decode stage: unit codes,
// operation codes, opcode constants and the decoded-instruction record.
package decode_stage_buffered_pkg;

  typedef enum logic [3:0] {
    UNIT_NONE   = 4'd0,
    UNIT_ALU    = 4'd1,
    UNIT_BRANCH = 4'd2,
    UNIT_MEM    = 4'd3
  } unit_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [4:0] OP_ADDI = 5'b10000;
  localparam logic [4:0] OP_JAL  = 5'b01000;
  localparam logic [4:0] OP_JALR = 5'b01001;

  typedef struct packed {
    unit_t       unit;
    logic [4:0]  op;
    logic [31:0] imm;
    logic        use_rs1;
    logic        use_rs2;
    logic        rd_write;
    logic        pc_op1;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/decode_stage_buffered_fifo.sv
// Circular fetch buffer with occupancy count; flush empties it and drops
// a same-cycle push. DEPTH must be a power of two so pointers wrap freely.
module decode_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;
  assign data_o  = mem[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PTR_W'(1);
      if (pop_ok)  rptr_q <= rptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage_buffered.sv
// Buffered RV32I decode stage: fetch buffer, register file, busy-bit scoreboard
// and registered execute output. Define DECODE_BYPASS_EN to forward writeback.
module decode_stage_buffered
  import decode_stage_buffered_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 4,
  parameter int NUM_REGS  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         getir_valid_i,
  output logic                         getir_ready_o,
  input  logic [31:0]                  getir_buyruk_i,
  input  logic [XLEN-1:0]              getir_ps_i,
  input  logic                         writeback_enable_i,
  input  logic [4:0]                   writeback_address_i,
  input  logic [XLEN-1:0]              writeback_result_i,
  output logic                         yurut_valid_o,
  input  logic                         yurut_ready_i,
  output logic [3:0]                   yurut_birim_secimi_o,
  output logic [4:0]                   yurut_islem_secimi_o,
  output logic [XLEN-1:0]              yurut_integer_deger1_o,
  output logic [XLEN-1:0]              yurut_integer_deger2_o,
  output logic [XLEN-1:0]              yurut_immidiate_o,
  output logic [XLEN-1:0]              yurut_ps_yeni_o,
  output logic [4:0]                   yurut_rd_adres_o,
  output logic                         yurut_rd_write_o,
  output logic                         yurut_illegal_o,
  output logic [$clog2(BUF_DEPTH):0]   buf_count_o
);

  function automatic logic [31:0] imm_i(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]};
  endfunction
  function automatic logic [31:0] imm_s(input logic [31:0] w);
    return {{20{w[31]}}, w[31:25], w[11:7]};
  endfunction
  function automatic logic [31:0] imm_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction
  function automatic logic [31:0] imm_u(input logic [31:0] w);
    return {w[31:12], 12'b0};
  endfunction
  function automatic logic [31:0] imm_j(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  logic [31:0]           head_instr;
  logic [XLEN-1:0]       head_pc;
  logic                  fifo_full, fifo_empty, issue, hazard;
  logic [4:0]            rs1, rs2, rd;
  logic [2:0]            f3;
  dec_t                  dec;
  logic [XLEN-1:0]       regs [NUM_REGS];
  logic [XLEN-1:0]       rs1_val, rs2_val;
  logic [NUM_REGS-1:0]   busy_q, busy_nxt, busy_chk;

  decode_fifo #(.WIDTH(32 + XLEN), .DEPTH(BUF_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (getir_valid_i),
    .pop_i   (issue),
    .data_i  ({getir_ps_i, getir_buyruk_i}),
    .data_o  ({head_pc, head_instr}),
    .count_o (buf_count_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign getir_ready_o = !fifo_full;
  assign rd  = head_instr[11:7];
  assign f3  = head_instr[14:12];
  assign rs1 = head_instr[19:15];
  assign rs2 = head_instr[24:20];

  // p0: combinational decode of the buffer head
  always_comb begin
    dec = '0;
    case (head_instr[6:0])
      OPC_OP:     begin dec.unit = UNIT_ALU; dec.op = {1'b0, head_instr[30], f3};
                        dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1; dec.rd_write = 1'b1; end
      OPC_OP_IMM: begin dec.unit = UNIT_ALU; dec.op = {1'b1, (f3 == 3'b101) && head_instr[30], f3};
                        dec.imm = imm_i(head_instr); dec.use_rs1 = 1'b1; dec.rd_write = 1'b1; end
      OPC_LUI:    begin dec.unit = UNIT_ALU; dec.op = OP_ADDI; dec.imm = imm_u(head_instr);
                        dec.rd_write = 1'b1; end
      OPC_AUIPC:  begin dec.unit = UNIT_ALU; dec.op = OP_ADDI; dec.imm = imm_u(head_instr);
                        dec.pc_op1 = 1'b1; dec.rd_write = 1'b1; end
      OPC_BRANCH: begin dec.unit = UNIT_BRANCH; dec.op = {2'b00, f3}; dec.imm = imm_b(head_instr);
                        dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1; end
      OPC_JAL:    begin dec.unit = UNIT_BRANCH; dec.op = OP_JAL; dec.imm = imm_j(head_instr);
                        dec.rd_write = 1'b1; end
      OPC_JALR:   begin dec.unit = UNIT_BRANCH; dec.op = OP_JALR; dec.imm = imm_i(head_instr);
                        dec.use_rs1 = 1'b1; dec.rd_write = 1'b1; end
      OPC_LOAD:   begin dec.unit = UNIT_MEM; dec.op = {2'b00, f3}; dec.imm = imm_i(head_instr);
                        dec.use_rs1 = 1'b1; dec.rd_write = 1'b1; end
      OPC_STORE:  begin dec.unit = UNIT_MEM; dec.op = {2'b10, f3}; dec.imm = imm_s(head_instr);
                        dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1; end
      default:    dec.illegal = 1'b1;
    endcase
    dec.rd_write = dec.rd_write && (rd != 5'd0);
  end

  always_comb begin
    rs1_val  = (rs1 == 5'd0) ? '0 : regs[rs1];
    rs2_val  = (rs2 == 5'd0) ? '0 : regs[rs2];
    busy_chk = busy_q;
`ifdef DECODE_BYPASS_EN
    if (writeback_enable_i && writeback_address_i != 5'd0) begin
      if (writeback_address_i == rs1) rs1_val = writeback_result_i;
      if (writeback_address_i == rs2) rs2_val = writeback_result_i;
      busy_chk[writeback_address_i] = 1'b0;
    end
`endif
  end

  assign hazard = (dec.use_rs1 && busy_chk[rs1]) || (dec.use_rs2 && busy_chk[rs2]) ||
                  (dec.rd_write && busy_chk[rd]);
  assign issue  = !fifo_empty && !hazard && (!yurut_valid_o || yurut_ready_i) && !flush_i;

  always_ff @(posedge clk_i) begin
    if (writeback_enable_i && writeback_address_i != 5'd0)
      regs[writeback_address_i] <= writeback_result_i;
  end

  // Writeback clears first so a same-edge issue to that rd keeps it busy.
  always_comb begin
    busy_nxt = busy_q;
    if (writeback_enable_i) busy_nxt[writeback_address_i] = 1'b0;
    if (flush_i) begin
      if (yurut_valid_o && yurut_rd_write_o) busy_nxt[yurut_rd_adres_o] = 1'b0;
    end else if (issue && dec.rd_write) begin
      busy_nxt[rd] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  // p1: registered execute-side output
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      yurut_valid_o          <= 1'b0;
      yurut_birim_secimi_o   <= '0;
      yurut_islem_secimi_o   <= '0;
      yurut_integer_deger1_o <= '0;
      yurut_integer_deger2_o <= '0;
      yurut_immidiate_o      <= '0;
      yurut_ps_yeni_o        <= '0;
      yurut_rd_adres_o       <= '0;
      yurut_rd_write_o       <= 1'b0;
      yurut_illegal_o        <= 1'b0;
    end else if (flush_i) begin
      yurut_valid_o <= 1'b0;
    end else if (issue) begin
      yurut_valid_o          <= 1'b1;
      yurut_birim_secimi_o   <= dec.unit;
      yurut_islem_secimi_o   <= dec.op;
      yurut_integer_deger1_o <= dec.pc_op1 ? head_pc : (dec.use_rs1 ? rs1_val : '0);
      yurut_integer_deger2_o <= dec.use_rs2 ? rs2_val : '0;
      yurut_immidiate_o      <= dec.imm;
      yurut_ps_yeni_o        <= head_pc;
      yurut_rd_adres_o       <= rd;
      yurut_rd_write_o       <= dec.rd_write;
      yurut_illegal_o        <= dec.illegal;
    end else if (yurut_ready_i) begin
      yurut_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage_buffered.sv
// Directed self-checking bench for decode_stage_buffered (BUF_DEPTH=4).
module tb_decode_stage_buffered;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, getir_valid_i, getir_ready_o;
  logic [31:0] getir_buyruk_i, getir_ps_i;
  logic        writeback_enable_i;
  logic [4:0]  writeback_address_i;
  logic [31:0] writeback_result_i;
  logic        yurut_valid_o, yurut_ready_i;
  logic [3:0]  yurut_birim_secimi_o;
  logic [4:0]  yurut_islem_secimi_o;
  logic [31:0] yurut_integer_deger1_o, yurut_integer_deger2_o, yurut_immidiate_o, yurut_ps_yeni_o;
  logic [4:0]  yurut_rd_adres_o;
  logic        yurut_rd_write_o, yurut_illegal_o;
  logic [2:0]  buf_count_o;
  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  decode_stage_buffered #(.XLEN(32), .BUF_DEPTH(4), .NUM_REGS(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .getir_valid_i(getir_valid_i), .getir_ready_o(getir_ready_o),
    .getir_buyruk_i(getir_buyruk_i), .getir_ps_i(getir_ps_i),
    .writeback_enable_i(writeback_enable_i), .writeback_address_i(writeback_address_i),
    .writeback_result_i(writeback_result_i),
    .yurut_valid_o(yurut_valid_o), .yurut_ready_i(yurut_ready_i),
    .yurut_birim_secimi_o(yurut_birim_secimi_o), .yurut_islem_secimi_o(yurut_islem_secimi_o),
    .yurut_integer_deger1_o(yurut_integer_deger1_o), .yurut_integer_deger2_o(yurut_integer_deger2_o),
    .yurut_immidiate_o(yurut_immidiate_o), .yurut_ps_yeni_o(yurut_ps_yeni_o),
    .yurut_rd_adres_o(yurut_rd_adres_o), .yurut_rd_write_o(yurut_rd_write_o),
    .yurut_illegal_o(yurut_illegal_o), .buf_count_o(buf_count_o)
  );

  function automatic logic [31:0] f_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] f_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    getir_valid_i = 1'b1; getir_buyruk_i = instr; getir_ps_i = pc;
    tick();
    getir_valid_i = 1'b0;
  endtask

  task automatic writeback(input logic [4:0] a, input logic [31:0] d);
    writeback_enable_i = 1'b1; writeback_address_i = a; writeback_result_i = d;
    tick();
    writeback_enable_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    tick(); tick();
    checks++; if (yurut_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", yurut_valid_o); end
    checks++; if (getir_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", getir_ready_o); end
    checks++; if (buf_count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", buf_count_o); end
    checks++; if (yurut_birim_secimi_o !== 4'd0) begin errors++; $display("FAIL reset_unit got %0d want 0", yurut_birim_secimi_o); end
    checks++; if (yurut_integer_deger1_o !== 32'd0) begin errors++; $display("FAIL reset_deger1 got %h want 0", yurut_integer_deger1_o); end
    rst_i = 1'b1;
  endtask

  task automatic test_addi();
    yurut_ready_i = 1'b1;
    push(32'h55500013, 32'h40);
    checks++; if (buf_count_o !== 3'd1) begin errors++; $display("FAIL addi_count got %0d want 1", buf_count_o); end
    checks++; if (yurut_valid_o !== 1'b0) begin errors++; $display("FAIL addi_early_valid got %0b want 0", yurut_valid_o); end
    tick();
    checks++; if (yurut_valid_o !== 1'b1) begin errors++; $display("FAIL addi_valid got %0b want 1", yurut_valid_o); end
    checks++; if (yurut_birim_secimi_o !== 4'd1) begin errors++; $display("FAIL addi_unit got %0d want 1", yurut_birim_secimi_o); end
    checks++; if (yurut_islem_secimi_o !== 5'b10000) begin errors++; $display("FAIL addi_op got %b want 10000", yurut_islem_secimi_o); end
    checks++; if (yurut_immidiate_o !== 32'h555) begin errors++; $display("FAIL addi_imm got %h want 555", yurut_immidiate_o); end
    checks++; if (yurut_rd_write_o !== 1'b0) begin errors++; $display("FAIL addi_rdw got %0b want 0", yurut_rd_write_o); end
    checks++; if (yurut_ps_yeni_o !== 32'h40) begin errors++; $display("FAIL addi_ps got %h want 40", yurut_ps_yeni_o); end
    tick();
    checks++; if (yurut_valid_o !== 1'b0) begin errors++; $display("FAIL addi_drain got %0b want 0", yurut_valid_o); end
  endtask

  task automatic test_raw();
    writeback(5'd5, 32'h10);
    push(f_addi(5'd6, 5'd5, 12'd1), 32'h100);
    push(f_add(5'd7, 5'd6, 5'd5), 32'h104);
    checks++; if (yurut_rd_adres_o !== 5'd6 || yurut_valid_o !== 1'b1) begin errors++; $display("FAIL raw_first got v=%0b rd=%0d want v=1 rd=6", yurut_valid_o, yurut_rd_adres_o); end
    checks++; if (yurut_integer_deger1_o !== 32'h10) begin errors++; $display("FAIL raw_first_op1 got %h want 10", yurut_integer_deger1_o); end
    tick(); tick();
    checks++; if (yurut_valid_o !== 1'b0 || buf_count_o !== 3'd1) begin errors++; $display("FAIL raw_stall got v=%0b cnt=%0d want v=0 cnt=1", yurut_valid_o, buf_count_o); end
    writeback(5'd6, 32'h11);
`ifndef DECODE_BYPASS_EN
    checks++; if (yurut_valid_o !== 1'b0) begin errors++; $display("FAIL raw_wb_cycle got %0b want 0", yurut_valid_o); end
    tick();
`endif
    checks++; if (yurut_valid_o !== 1'b1 || yurut_rd_adres_o !== 5'd7) begin errors++; $display("FAIL raw_issue got v=%0b rd=%0d want v=1 rd=7", yurut_valid_o, yurut_rd_adres_o); end
    checks++; if (yurut_integer_deger1_o !== 32'h11) begin errors++; $display("FAIL raw_op1 got %h want 11", yurut_integer_deger1_o); end
    checks++; if (yurut_integer_deger2_o !== 32'h10) begin errors++; $display("FAIL raw_op2 got %h want 10", yurut_integer_deger2_o); end
    checks++; if (yurut_islem_secimi_o !== 5'b00000) begin errors++; $display("FAIL raw_opcode got %b want 00000", yurut_islem_secimi_o); end
    writeback(5'd7, 32'h21);
  endtask

  task automatic test_full();
    logic [4:0] exp_rd;
    int idx;
    logic accept;
    yurut_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push(f_addi(5'(10 + i), 5'd0, 12'(i)), 32'h200 + 32'(4 * i));
    checks++; if (getir_ready_o !== 1'b0 || buf_count_o !== 3'd4) begin errors++; $display("FAIL full_state got rdy=%0b cnt=%0d want rdy=0 cnt=4", getir_ready_o, buf_count_o); end
    getir_valid_i = 1'b1; getir_buyruk_i = f_addi(5'd15, 5'd0, 12'd5); getir_ps_i = 32'h214;
    tick(); tick();
    checks++; if (buf_count_o !== 3'd4) begin errors++; $display("FAIL full_hold_count got %0d want 4", buf_count_o); end
    checks++; if (yurut_valid_o !== 1'b1 || yurut_rd_adres_o !== 5'd10 || yurut_ps_yeni_o !== 32'h200) begin
      errors++; $display("FAIL full_stable got v=%0b rd=%0d ps=%h want v=1 rd=10 ps=200", yurut_valid_o, yurut_rd_adres_o, yurut_ps_yeni_o); end
    yurut_ready_i = 1'b1;
    idx = 0;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      if (yurut_valid_o) begin
        exp_rd = 5'(10 + idx);
        checks++; if (yurut_rd_adres_o !== exp_rd) begin errors++; $display("FAIL full_order got rd=%0d want %0d", yurut_rd_adres_o, exp_rd); end
        idx++;
      end
      accept = getir_valid_i && getir_ready_o;
      tick();
      if (accept) getir_valid_i = 1'b0;
    end
    checks++; if (idx !== 6) begin errors++; $display("FAIL full_drained got %0d want 6", idx); end
    getir_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    yurut_ready_i = 1'b0;
    push(f_addi(5'd3, 5'd0, 12'd7), 32'h300);
    tick();
    checks++; if (yurut_valid_o !== 1'b1 || yurut_rd_adres_o !== 5'd3) begin errors++; $display("FAIL flush_pre got v=%0b rd=%0d want v=1 rd=3", yurut_valid_o, yurut_rd_adres_o); end
    flush_i = 1'b1;
    push(32'h0000007F, 32'h3F0);
    flush_i = 1'b0;
    checks++; if (yurut_valid_o !== 1'b0 || buf_count_o !== 3'd0) begin errors++; $display("FAIL flush_clear got v=%0b cnt=%0d want v=0 cnt=0", yurut_valid_o, buf_count_o); end
    yurut_ready_i = 1'b1;
    push(f_addi(5'd4, 5'd3, 12'd0), 32'h304);
    tick();
    checks++; if (yurut_valid_o !== 1'b1 || yurut_rd_adres_o !== 5'd4 || yurut_ps_yeni_o !== 32'h304) begin
      errors++; $display("FAIL flush_nostall got v=%0b rd=%0d ps=%h want v=1 rd=4 ps=304", yurut_valid_o, yurut_rd_adres_o, yurut_ps_yeni_o); end
    tick();
  endtask

  task automatic test_bypass();
    yurut_ready_i = 1'b1;
    push(f_addi(5'd9, 5'd0, 12'd5), 32'h400);
    push(f_add(5'd20, 5'd9, 5'd0), 32'h404);
    tick();
    checks++; if (yurut_valid_o !== 1'b0 || buf_count_o !== 3'd1) begin errors++; $display("FAIL byp_stall got v=%0b cnt=%0d want v=0 cnt=1", yurut_valid_o, buf_count_o); end
    writeback(5'd9, 32'h99);
`ifdef DECODE_BYPASS_EN
    checks++; if (yurut_valid_o !== 1'b1) begin errors++; $display("FAIL byp_same_cycle got %0b want 1", yurut_valid_o); end
`else
    checks++; if (yurut_valid_o !== 1'b0) begin errors++; $display("FAIL byp_wait got %0b want 0", yurut_valid_o); end
    tick();
    checks++; if (yurut_valid_o !== 1'b1) begin errors++; $display("FAIL byp_late got %0b want 1", yurut_valid_o); end
`endif
    checks++; if (yurut_integer_deger1_o !== 32'h99 || yurut_rd_adres_o !== 5'd20) begin
      errors++; $display("FAIL byp_data got op1=%h rd=%0d want op1=99 rd=20", yurut_integer_deger1_o, yurut_rd_adres_o); end
    tick();
  endtask

  task automatic test_illegal();
    yurut_ready_i = 1'b1;
    push(32'h0000007F, 32'h500);
    push(32'h00000F7F, 32'h504);
    checks++; if (yurut_valid_o !== 1'b1 || yurut_birim_secimi_o !== 4'd0 || yurut_illegal_o !== 1'b1) begin
      errors++; $display("FAIL ill_decode got v=%0b unit=%0d ill=%0b want v=1 unit=0 ill=1", yurut_valid_o, yurut_birim_secimi_o, yurut_illegal_o); end
    checks++; if (yurut_rd_write_o !== 1'b0 || yurut_islem_secimi_o !== 5'd0) begin errors++; $display("FAIL ill_fields got rdw=%0b op=%b want 0 00000", yurut_rd_write_o, yurut_islem_secimi_o); end
    push(f_addi(5'd1, 5'd30, 12'd0), 32'h508);
    checks++; if (yurut_illegal_o !== 1'b1 || yurut_rd_adres_o !== 5'd30 || yurut_rd_write_o !== 1'b0) begin
      errors++; $display("FAIL ill_rd30 got ill=%0b rd=%0d rdw=%0b want 1 30 0", yurut_illegal_o, yurut_rd_adres_o, yurut_rd_write_o); end
    tick();
    checks++; if (yurut_valid_o !== 1'b1 || yurut_rd_adres_o !== 5'd1 || yurut_illegal_o !== 1'b0) begin
      errors++; $display("FAIL ill_nobusy got v=%0b rd=%0d ill=%0b want v=1 rd=1 ill=0", yurut_valid_o, yurut_rd_adres_o, yurut_illegal_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    yurut_ready_i = 1'b0;
    push(f_addi(5'd16, 5'd0, 12'd1), 32'h600);
    push(f_addi(5'd17, 5'd0, 12'd2), 32'h604);
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    checks++; if (yurut_valid_o !== 1'b0 || buf_count_o !== 3'd0 || getir_ready_o !== 1'b1) begin
      errors++; $display("FAIL rstmid got v=%0b cnt=%0d rdy=%0b want 0 0 1", yurut_valid_o, buf_count_o, getir_ready_o); end
    yurut_ready_i = 1'b1;
    push(f_addi(5'd18, 5'd10, 12'd0), 32'h608);
    tick();
    checks++; if (yurut_valid_o !== 1'b1 || yurut_rd_adres_o !== 5'd18) begin errors++; $display("FAIL rstmid_busy got v=%0b rd=%0d want v=1 rd=18", yurut_valid_o, yurut_rd_adres_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b0; flush_i = 1'b0; getir_valid_i = 1'b0; getir_buyruk_i = '0; getir_ps_i = '0;
    writeback_enable_i = 1'b0; writeback_address_i = '0; writeback_result_i = '0; yurut_ready_i = 1'b1;
    test_reset();
    test_addi();
    test_raw();
    test_full();
    test_flush();
    test_bypass();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
